core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Run controller for the 16-bit CPU core and its 32-word, 16-bit program/data memory.
- Owns the single memory port: a host streams a program in, requests a run, and reads memory back afterwards.
- During a run, the core reaches memory through this block's mux. The block drives the core's reset and start_execution, and stops the run when the core halts or a watchdog expires.

Parameters:
- ADDR_WIDTH, 5, memory address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 16, memory word width
- CYCLE_WIDTH, 16, width of run-cycle counter
- MAX_CYCLES, 4095, watchdog limit in clock cycles; must be less than 2**CYCLE_WIDTH

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- load_valid  input  1  host program word valid
- load_ready  output  1  sequencer accepts load word
- load_data  input  DATA_WIDTH  program word
- load_last  input  1  final word of program
- run_req  input  1  start a run (level, sampled in IDLE)
- dump_req  input  1  start memory readback (sampled in IDLE)
- dump_valid  output  1  readback word valid
- dump_ready  input  1  host accepts readback word
- dump_data  output  DATA_WIDTH  readback word
- dump_addr  output  ADDR_WIDTH  address of dump_data
- core_reset  output  1  active-high reset to core
- core_start  output  1  core start_execution
- core_halted  input  1  core halted flag
- core_mem_addr  input  ADDR_WIDTH  core memory address
- core_mem_wdata  input  DATA_WIDTH  core write data
- core_mem_write  input  1  core write enable
- core_mem_rdata  output  DATA_WIDTH  read data to core
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_write  output  1  memory write enable, written on clock rise
- mem_rdata  input  DATA_WIDTH  memory read data, combinational from mem_addr
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at run end
- timeout  output  1  sticky: last run hit watchdog
- cycle_count  output  CYCLE_WIDTH  cycles spent in RUN for last/current run

Behaviour:
- Reset (reset=0, async): state=IDLE, all pointers/counters=0.
  - Outputs: load_ready=0, dump_valid=0, dump_data=0, dump_addr=0, core_reset=1, core_start=0, mem_write=0, mem_addr=0, mem_wdata=0, busy=0, done=0, timeout=0, cycle_count=0.
- core_reset stays 1 in every state except RUN. Reset mid-run or mid-load aborts immediately; memory contents are undefined to the host afterwards.
- core_mem_rdata = mem_rdata at all times. Core address/write fields drive the memory only in RUN; otherwise core_mem_write is ignored.
- States: IDLE, LOAD, CORE_CLR, RUN, DONE, DUMP.
- IDLE request priority: run_req > load_valid > dump_req.
  - run_req: go to CORE_CLR, clear cycle_count and timeout.
  - load_valid: go to LOAD, load_ptr=0. The word is not accepted in this cycle.
  - dump_req: go to DUMP, dump_ptr=0.
- LOAD:
  - load_ready=1.
  - On each load_valid&load_ready in the same cycle: mem_write=1, mem_addr=load_ptr, mem_wdata=load_data, load_ptr+1.
  - Exit to IDLE on the accepted word with load_last=1, or on the accepted word at load_ptr=depth-1 (no wrap; load_last ignored there).
  - load_ready drops in the IDLE cycle after exit. Unwritten words keep their prior contents.
- CORE_CLR: core_reset=1 for exactly 2 cycles, then go to RUN.
- RUN:
  - core_reset=0, core_start=1; memory muxed to the core.
  - cycle_count increments every RUN cycle, saturating at its maximum value.
  - If core_halted=1, go to DONE. Halted takes priority over the watchdog in the same cycle.
  - Else if cycle_count==MAX_CYCLES, set timeout=1 and go to DONE.
  - core_start=0 and core_reset=1 from the first DONE cycle.
- DONE: done=1 for exactly one cycle, then go to IDLE. cycle_count holds its value until the next run_req is accepted.
- DUMP:
  - mem_addr=dump_ptr; dump_data/dump_addr are registered from mem_rdata/dump_ptr; dump_valid=1.
  - dump_data and dump_addr stay stable while dump_valid&!dump_ready.
  - On a handshake: dump_ptr+1, next word presented the next cycle (one word per cycle when dump_ready is held at 1).
  - After the handshake at address depth-1: dump_valid=0, go to IDLE.
- run_req, load_valid and dump_req are ignored outside IDLE.

Test Plan:
- Load 4 words (0x1234, 0xABCD, 0x0000, 0xFFFF, load_last on the 4th) -> mem[0..3] equal those values; load_ready=0 the next cycle; busy=0.
- Load 40 words with no load_last -> exactly 32 words written (mem[31]=word 31); words 33-40 see load_ready=0.
- Core halts after 10 RUN cycles -> core_reset low for 10 cycles; done pulses one cycle; cycle_count=10; timeout=0.
- Core never halts, MAX_CYCLES=20 -> timeout=1, cycle_count=20, core_start=0 next cycle.
- Dump with dump_ready toggling 1,0,1 -> addresses 0..31 in order with data matching memory; data held during stalls.
- Assert reset low mid-RUN for 1 cycle -> all outputs at reset values immediately (core_reset=1); run_req plus load_valid together afterwards -> CORE_CLR entered.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: run controller for the 16-bit core and its shared program/data memory.
// Owns the single memory port. A host streams a program in (LOAD), requests a run
// (CORE_CLR -> RUN -> DONE) or reads memory back (DUMP). During RUN the core drives
// the memory through this block; a watchdog bounds the run length.
//
// Handshakes: load_* and dump_* use valid/ready. A word moves on a rising clock edge
// where valid and ready are both 1. The sender holds its word stable while valid=1
// and ready=0, and valid never waits on ready.
module core_sequencer #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int CYCLE_WIDTH = 16,
    parameter int MAX_CYCLES  = 4095
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic                   load_last,
    input  logic                   run_req,
    input  logic                   dump_req,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [DATA_WIDTH-1:0]  dump_data,
    output logic [ADDR_WIDTH-1:0]  dump_addr,
    output logic                   core_reset,
    output logic                   core_start,
    input  logic                   core_halted,
    input  logic [ADDR_WIDTH-1:0]  core_mem_addr,
    input  logic [DATA_WIDTH-1:0]  core_mem_wdata,
    input  logic                   core_mem_write,
    output logic [DATA_WIDTH-1:0]  core_mem_rdata,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   mem_write,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [CYCLE_WIDTH-1:0] cycle_count,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_CORE_CLR = 3'd2,
        S_RUN      = 3'd3,
        S_DONE     = 3'd4,
        S_DUMP     = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = '1;
    localparam logic [CYCLE_WIDTH-1:0] CYCLE_SAT = '1;
    localparam logic [CYCLE_WIDTH-1:0] WATCHDOG  = CYCLE_WIDTH'(MAX_CYCLES);

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  load_ptr;
    logic [ADDR_WIDTH-1:0]  dump_ptr;     // next address to fetch for readback
    logic                   clr_cnt;      // 0 in first CORE_CLR cycle, 1 in second
    logic [CYCLE_WIDTH-1:0] cycle_inc;    // count including the current RUN cycle
    logic                   watchdog_hit;

    // The watchdog compares the count that includes the current cycle, so a run
    // that never halts spends exactly MAX_CYCLES cycles in RUN.
    assign cycle_inc      = (cycle_count == CYCLE_SAT) ? cycle_count : cycle_count + 1'b1;
    assign watchdog_hit   = (cycle_inc == WATCHDOG);
    assign core_mem_rdata = mem_rdata;
    assign busy           = (state != S_IDLE);
    assign state_dbg      = state;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the memory-port mux / control outputs.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        core_reset = 1'b1;
        core_start = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_write  = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_req) begin
                    state_next = S_CORE_CLR;
                end else if (load_valid) begin
                    state_next = S_LOAD;
                end else if (dump_req) begin
                    state_next = S_DUMP;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                mem_addr   = load_ptr;
                mem_wdata  = load_data;
                mem_write  = load_valid;
                if (load_valid && (load_last || load_ptr == LAST_ADDR)) begin
                    state_next = S_IDLE;
                end
            end
            S_CORE_CLR: begin
                if (clr_cnt) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                core_reset = 1'b0;
                core_start = 1'b1;
                mem_addr   = core_mem_addr;
                mem_wdata  = core_mem_wdata;
                mem_write  = core_mem_write;
                if (core_halted || watchdog_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_DUMP: begin
                mem_addr = dump_ptr;
                if (dump_valid && dump_ready && dump_addr == LAST_ADDR) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Pointers, run counters and the registered readback word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_ptr    <= '0;
            dump_ptr    <= '0;
            clr_cnt     <= 1'b0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            dump_valid  <= 1'b0;
            dump_data   <= '0;
            dump_addr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run_req) begin
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                        clr_cnt     <= 1'b0;
                    end else if (load_valid) begin
                        load_ptr <= '0;
                    end else if (dump_req) begin
                        dump_ptr   <= '0;
                        dump_valid <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        load_ptr <= load_ptr + 1'b1;
                    end
                end
                S_CORE_CLR: begin
                    clr_cnt <= 1'b1;
                end
                S_RUN: begin
                    cycle_count <= cycle_inc;
                    if (!core_halted && watchdog_hit) begin
                        timeout <= 1'b1;
                    end
                end
                S_DUMP: begin
                    // Refill the output register when it is empty or being taken.
                    if (!dump_valid || dump_ready) begin
                        if (dump_valid && dump_addr == LAST_ADDR) begin
                            dump_valid <= 1'b0;
                        end else begin
                            dump_data  <= mem_rdata;
                            dump_addr  <= dump_ptr;
                            dump_valid <= 1'b1;
                            dump_ptr   <= dump_ptr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed bench for core_sequencer with a 32-word memory model
// and a simple core model that can halt after a fixed number of RUN cycles.
module tb_core_sequencer;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam logic [2:0] ST_CORE_CLR = 3'd2;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          run_req;
    logic          dump_req;
    logic          dump_valid;
    logic          dump_ready;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_addr;
    logic          core_reset;
    logic          core_start;
    logic          core_halted;
    logic [AW-1:0] core_mem_addr;
    logic [DW-1:0] core_mem_wdata;
    logic          core_mem_write;
    logic [DW-1:0] core_mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;
    logic [2:0]    state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    core_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CYCLE_WIDTH(CW),
        .MAX_CYCLES (20)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_last     (load_last),
        .run_req       (run_req),
        .dump_req      (dump_req),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_data     (dump_data),
        .dump_addr     (dump_addr),
        .core_reset    (core_reset),
        .core_start    (core_start),
        .core_halted   (core_halted),
        .core_mem_addr (core_mem_addr),
        .core_mem_wdata(core_mem_wdata),
        .core_mem_write(core_mem_write),
        .core_mem_rdata(core_mem_rdata),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_write     (mem_write),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .cycle_count   (cycle_count),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end, required summary before 100000ns");
        $fatal(1, "bench time limit");
    end

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [0:31];
    logic          mem_init_done = 1'b0;

    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 32; i++) mem[i] <= 16'(16'h5A00 + i);
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    // ---------------- core model ----------------
    logic          halt_en  = 1'b0;
    logic          cw_force = 1'b0;
    logic [DW-1:0] cw_data  = 16'hC0DE;
    int            run_cnt  = 0;
    int            low_cnt  = 0;

    always @(posedge clock) begin
        if (core_reset) run_cnt <= 0;
        else            run_cnt <= run_cnt + 1;
    end
    always @(negedge clock) begin
        if (!core_reset) low_cnt <= low_cnt + 1;
    end
    // Halts in the 10th RUN cycle; writes mem[5] in the 3rd RUN cycle of that run.
    assign core_halted    = halt_en && (run_cnt == 9);
    assign core_mem_addr  = 5'd5;
    assign core_mem_wdata = cw_data;
    assign core_mem_write = cw_force || (halt_en && run_cnt == 2);

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [DW-1:0] d, input logic last, output logic accepted);
        accepted   = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        for (int i = 0; i < 4 && !accepted; i++) begin
            @(negedge clock);
            if (load_ready) accepted = 1'b1;
            @(posedge clock);
            #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_run_end(input string tag, input logic [CW-1:0] exp_cc, input logic exp_to,
                                input int low_start, input int exp_low);
        int ndone   = 0;
        bit at_idle = 1'b0;
        for (int i = 0; i < 100 && !at_idle; i++) begin
            @(negedge clock);
            if (done) begin
                ndone++;
                check_val({tag, "_cycle_count"}, cycle_count, exp_cc);
                check_val({tag, "_timeout"}, timeout, exp_to);
                check_val({tag, "_core_start_in_done"}, core_start, 0);
                check_val({tag, "_core_reset_in_done"}, core_reset, 1);
            end else if (ndone > 0 && !busy) begin
                at_idle = 1'b1;
            end
        end
        check_val({tag, "_done_pulses"}, ndone, 1);
        check_val({tag, "_back_to_idle"}, at_idle, 1);
        check_val({tag, "_core_reset_low_cycles"}, low_cnt - low_start, exp_low);
    endtask

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_mem [0:31];

    // ---------------- main sequence ----------------
    initial begin
        logic          acc;
        int            n_acc;
        int            low_start;
        int            n_dump;
        logic [DW-1:0] t1 [4];

        t1 = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF};
        reset = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        run_req = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;

        repeat (2) @(negedge clock);
        mem_init_done = 1'b1;

        // Reset values
        check_val("rst_load_ready", load_ready, 0);
        check_val("rst_dump_valid", dump_valid, 0);
        check_val("rst_dump_data", dump_data, 0);
        check_val("rst_dump_addr", dump_addr, 0);
        check_val("rst_core_reset", core_reset, 1);
        check_val("rst_core_start", core_start, 0);
        check_val("rst_mem_write", mem_write, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_wdata", mem_wdata, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_cycle_count", cycle_count, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Load 4 words, last on the 4th
        for (int i = 0; i < 4; i++) begin
            send_word(t1[i], (i == 3), acc);
            check_val("load4_accepted", acc, 1);
        end
        @(negedge clock);
        check_val("load4_ready_after", load_ready, 0);
        check_val("load4_busy_after", busy, 0);
        for (int i = 0; i < 4; i++) check_val("load4_mem", mem[i], t1[i]);
        check_val("load4_mem4_kept", mem[4], 16'h5A04);
        @(posedge clock); #1;

        // Load 40 words without last; only 32 land
        n_acc = 0;
        for (int i = 0; i < 32; i++) begin
            send_word(16'(16'h4000 + i), 1'b0, acc);
            n_acc += int'(acc);
        end
        check_val("load40_accepted", n_acc, 32);

        // Words 33-40 offered together with run_req: run wins, words refused
        halt_en   = 1'b1;
        low_start = low_cnt;
        run_req   = 1'b1;
        load_valid = 1'b1;
        for (int k = 32; k < 40; k++) begin
            load_data = 16'(16'h4000 + k);
            @(negedge clock);
            check_val("load40_extra_ready", load_ready, 0);
            @(posedge clock); #1;
            run_req = 1'b0;
        end
        load_valid = 1'b0;
        wait_run_end("halt_run", 16'd10, 1'b0, low_start, 10);
        halt_en = 1'b0;
        check_val("load40_mem31", mem[31], 16'h401F);
        check_val("load40_mem0_no_wrap", mem[0], 16'h4000);
        check_val("run_core_write_mem5", mem[5], 16'hC0DE);
        for (int i = 0; i < 32; i++) exp_mem[i] = 16'(16'h4000 + i);
        exp_mem[5] = 16'hC0DE;
        @(posedge clock); #1;

        // Core write outside RUN is ignored
        cw_force = 1'b1;
        cw_data  = 16'hDEAD;
        @(negedge clock);
        check_val("idle_core_write_ignored", mem_write, 0);
        @(posedge clock); #1;
        cw_force = 1'b0;
        cw_data  = 16'hC0DE;

        // Watchdog run
        low_start = low_cnt;
        run_req = 1'b1;
        @(posedge clock); #1;
        run_req = 1'b0;
        wait_run_end("wdog_run", 16'd20, 1'b1, low_start, 20);
        @(posedge clock); #1;

        // Dump with dump_ready toggling 1,0,1,...
        for (int i = 0; i < 32; i++) exp_q.push_back(exp_mem[i]);
        dump_req = 1'b1;
        @(posedge clock); #1;
        dump_req = 1'b0;
        n_dump = 0;
        for (int c = 0; c < 200 && n_dump < 32; c++) begin
            dump_ready = (c % 2 == 0);
            @(negedge clock);
            if (dump_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("dump_extra_word", dump_valid, 0);
                end else begin
                    check_val("dump_data", dump_data, exp_q[0]);
                    check_val("dump_addr", dump_addr, n_dump);
                    if (dump_ready) begin
                        void'(exp_q.pop_front());
                        n_dump++;
                    end
                end
            end
            @(posedge clock); #1;
        end
        dump_ready = 1'b0;
        check_val("dump_word_count", n_dump, 32);
        @(negedge clock);
        check_val("dump_valid_after", dump_valid, 0);
        check_val("dump_busy_after", busy, 0);
        @(posedge clock); #1;

        // Reset asserted mid-RUN
        run_req = 1'b1;
        @(posedge clock); #1;
        run_req = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check_val("midrun_core_reset_low", core_reset, 0);
        check_val("midrun_cycle_count", cycle_count, 2);
        #1;
        reset = 1'b0;
        #1;
        check_val("arst_core_reset", core_reset, 1);
        check_val("arst_core_start", core_start, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_cycle_count", cycle_count, 0);
        check_val("arst_timeout", timeout, 0);
        check_val("arst_dump_data", dump_data, 0);
        check_val("arst_dump_addr", dump_addr, 0);
        check_val("arst_dump_valid", dump_valid, 0);
        check_val("arst_mem_write", mem_write, 0);
        check_val("arst_mem_addr", mem_addr, 0);
        check_val("arst_load_ready", load_ready, 0);
        check_val("arst_done", done, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // run_req and load_valid together: run has priority
        low_start  = low_cnt;
        run_req    = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h7777;
        @(posedge clock); #1;
        run_req    = 1'b0;
        load_valid = 1'b0;
        check_val("prio_state_core_clr", state_dbg, ST_CORE_CLR);
        check_val("prio_load_ready", load_ready, 0);
        check_val("prio_busy", busy, 1);
        wait_run_end("post_rst_run", 16'd20, 1'b1, low_start, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
